// File: rtl/adf4159_pkg.sv
// Shared constants, ADF4159 register indices and FSM state type for the serial receiver.
// No logic lives here.
package adf4159_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 3;

  // Control-bit values selecting ADF4159 registers R0..R7.
  localparam logic [ADDR_W-1:0] R0 = 3'd0;
  localparam logic [ADDR_W-1:0] R1 = 3'd1;
  localparam logic [ADDR_W-1:0] R2 = 3'd2;
  localparam logic [ADDR_W-1:0] R3 = 3'd3;
  localparam logic [ADDR_W-1:0] R4 = 3'd4;
  localparam logic [ADDR_W-1:0] R5 = 3'd5;
  localparam logic [ADDR_W-1:0] R6 = 3'd6;
  localparam logic [ADDR_W-1:0] R7 = 3'd7;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

endpackage

// File: rtl/adf4159_serial_receiver_bit_sync.sv
// Multi-flop synchroniser for one asynchronous input bit; SYNC_STAGES cycles of latency.
// No handshake: the input is sampled every cycle.
module bit_synchronizer #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_bit,
  output logic sync_bit
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {SYNC_STAGES{RST_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_bit};
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/adf4159_serial_receiver.sv
// ADF4159 3-wire bus receiver: deserialises MSB-first frames into an 8-entry shadow register file.
// word_valid_o fires SYNC_STAGES+2 cycles after LE rises at the pin; no backpressure, bus is free-running.
module adf4159_serial_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_W      = adf4159_pkg::WORD_W,
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = adf4159_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              CLK_i,
  input  logic              DATA_i,
  input  logic              LE_i,
  output logic [WORD_W-1:0] word_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic              word_valid_o,
  output logic              frame_error_o,
  output logic              busy_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  import adf4159_pkg::*;

  logic clk_s, data_s, le_s;
  logic clk_d, le_d;
  logic clk_rise, le_fall, le_rise;

  state_t            state_q;
  logic [WORD_W-1:0] shift_q;
  logic [5:0]        bit_cnt_q;
  logic [WORD_W-1:0] shadow_q [NUM_REGS];

  // Equal-depth synchronisers keep DATA aligned with the CLK edge it belongs to.
  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk_i(clk_i), .rst_i(rst_i), .async_bit(CLK_i), .sync_bit(clk_s));
  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk_i(clk_i), .rst_i(rst_i), .async_bit(DATA_i), .sync_bit(data_s));
  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_le (
    .clk_i(clk_i), .rst_i(rst_i), .async_bit(LE_i), .sync_bit(le_s));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_d <= 1'b0;
      le_d  <= 1'b1;
    end else begin
      clk_d <= clk_s;
      le_d  <= le_s;
    end
  end

  assign clk_rise = clk_s & ~clk_d;
  assign le_fall  = ~le_s & le_d;
  assign le_rise  = le_s & ~le_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      word_o        <= '0;
      reg_addr_o    <= '0;
      word_valid_o  <= 1'b0;
      frame_error_o <= 1'b0;
      busy_o        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else begin
      word_valid_o  <= 1'b0;
      frame_error_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (le_fall) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            busy_o    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // A CLK rise coinciding with LE rise is still counted before committing.
          if (clk_rise) begin
            shift_q <= {shift_q[WORD_W-2:0], data_s};
            if (bit_cnt_q != '1) bit_cnt_q <= bit_cnt_q + 6'd1;
          end
          if (le_rise) state_q <= COMMIT;
        end
        COMMIT: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          if (bit_cnt_q == 6'(WORD_W)) begin
            word_o                       <= shift_q;
            reg_addr_o                   <= shift_q[ADDR_W-1:0];
            shadow_q[shift_q[ADDR_W-1:0]] <= shift_q;
            word_valid_o                 <= 1'b1;
          end else begin
            frame_error_o <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_o <= '0;
    else       rd_data_o <= shadow_q[rd_addr_i];
  end

endmodule
